sm_regs_bank: RTL and testbench
===============================

# sm_regs_bank

Parametrised AXI4-Lite slave register bank, successor to the fixed four-register SM_regs block. It provides C_NUM_REGS registers of C_DATA_WIDTH bits. Each register is either read/write control (driven to fabric) or read-only status (sampled from fabric), selected per register by a mask. It adds byte strobes, SLVERR on illegal accesses, and one-cycle access pulses so state-machine logic can react to host writes and reads.

## Interface
- C_DATA_WIDTH, 32: register and AXI data width; 32 or 64.
- C_NUM_REGS, 16: number of registers, 1..64.
- C_ADDR_WIDTH, 8: AXI address width; must satisfy 2^C_ADDR_WIDTH ≥ C_NUM_REGS·C_DATA_WIDTH/8.
- C_RO_MASK, 0: bit k = 1 makes register k read-only status.
- C_RESET_VAL, 0: flattened C_NUM_REGS·C_DATA_WIDTH reset image for the control registers.
- ACLK  in  1  single clock.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  C_ADDR_WIDTH/3/1/1  write address channel; AWPROT is ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  C_DATA_WIDTH/C_DATA_WIDTH/8/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  C_ADDR_WIDTH/3/1/1  read address channel; ARPROT is ignored.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  C_DATA_WIDTH/2/1/1  read data channel.
- ctrl_o  out  C_NUM_REGS·C_DATA_WIDTH  control register contents; slices for RO registers are driven 0.
- sts_i  in  C_NUM_REGS·C_DATA_WIDTH  status inputs, synchronous to ACLK; only RO slices are used.
- wr_pulse_o  out  C_NUM_REGS  one-cycle pulse per successful write.
- rd_pulse_o  out  C_NUM_REGS  one-cycle pulse per successful read.

## Operation
- Register index k = addr[C_ADDR_WIDTH-1:log2(C_DATA_WIDTH/8)]. Low address bits are ignored.
- **Write FSM states:**
  - W_IDLE: AWREADY = 1 until AW is latched; WREADY = 1 until W is latched. AW and W may arrive in either order or in the same cycle.
  - W_IDLE → W_RESP once both are latched.
  - W_RESP: BVALID = 1 and AWREADY = WREADY = 0 until BREADY; then → W_IDLE.
- **Write commit:**
  - k < C_NUM_REGS and RO bit = 0: update the bytes whose WSTRB bit is 1; BRESP = OKAY; wr_pulse_o[k] = 1.
  - k is RO or k ≥ C_NUM_REGS: no register change, no pulse, BRESP = SLVERR.
- **Read path:**
  - ARREADY = !RVALID.
  - On AR handshake, RDATA is loaded: ctrl register k if RW, sts_i slice k if RO. RVALID is set.
  - k ≥ C_NUM_REGS: RDATA = 0, RRESP = SLVERR, no pulse. Otherwise RRESP = OKAY and rd_pulse_o[k] = 1.
  - RVALID holds with stable data until RREADY.
- Read and write channels are independent and may complete in the same cycle. A read to the register being committed that cycle returns the pre-write value.
- **Reset (ARESETN low, asynchronous at any time, including mid-transaction):**
  - FSM → W_IDLE; latched AW/W are discarded.
  - BVALID = RVALID = 0; BRESP = RRESP = 0; RDATA = 0.
  - Pulse outputs = 0; ctrl registers = C_RESET_VAL.
  - AWREADY, WREADY and ARREADY are 0 while reset is asserted and rise on the first clock edge after deassertion.

## Timing
- Write: the later of the AW/W handshakes occurs at edge N. At N+1, BVALID = 1, the register holds its new value and wr_pulse_o is high for exactly that one cycle. The next AW can be accepted in the cycle after BREADY.
- Read: AR handshake at edge N. At N+1, RVALID = 1 and rd_pulse_o is high for one cycle. With RREADY held high, throughput is one read per 2 cycles.
- sts_i is sampled at the AR handshake edge; there is no additional synchroniser.

## Structure
- Package sm_regs_pkg holds:
  - the response constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the write FSM enum (W_IDLE, W_RESP);
  - the function addr_to_idx.
- One natural sub-module, sm_regs_wr_ch: the AW/W capture and B response FSM, which outputs a commit strobe, index and strobed data.
- Register array, read path and pulses live in the top level.

## Test plan
- Reset with default parameters → all ready signals = 0 during reset; after release, AWREADY = WREADY = ARREADY = 1, all ctrl_o = 0, BVALID = RVALID = 0.
- Write 0x0000000N to addresses 0x00..0x3C, then read each back → RDATA = N and OKAY every time; wr_pulse_o/rd_pulse_o show exactly one pulse each at the expected index.
- Write 0xAABBCCDD to 0x08 with WSTRB = 4'b0101 over the prior value 0x11223344 → reads back 0x11BB33DD.
- With C_RO_MASK bit 2 set and sts_i slice 2 = 0xCAFEF00D:
  - write 0x12345678 to 0x08 → SLVERR, no pulse;
  - read 0x08 → 0xCAFEF00D, OKAY.
- Read address 0x40 (k = 16) → RDATA = 0, SLVERR; write to 0x40 → SLVERR and no ctrl_o change.
- Edge cases:
  - W presented 3 cycles before AW → one commit, BVALID one cycle after the AW handshake;
  - BREADY held low 5 cycles → BVALID stays high and AWREADY stays 0;
  - ARESETN pulsed low while BVALID is pending → BVALID = 0 immediately, register = C_RESET_VAL.

Source files
------------

// File: rtl/sm_regs_pkg.sv
// Shared constants, write FSM states and address decode for sm_regs_bank.
package sm_regs_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Wide enough to index the largest supported bank (64 registers).
   localparam int unsigned IDX_W = 6;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } wr_state_e;

   // Word index of a byte address; the byte-lane bits are dropped.
   function automatic int unsigned addr_to_idx(input logic [31:0] addr,
                                               input int unsigned data_width);
      int unsigned shift;
      shift = (data_width == 64) ? 3 : 2;
      return addr >> shift;
   endfunction

   // One bit of a 64-bit per-register mask, selected by register index.
   function automatic logic mask_bit(input logic [63:0] mask, input int unsigned i);
      logic [5:0] b;
      b = i[5:0];
      return mask[b];
   endfunction

endpackage

// File: rtl/sm_regs_wr_ch.sv
// AXI4-Lite write channel: captures AW and W in any order, decides legality,
// issues a one-cycle commit strobe and holds the B response until BREADY.
module sm_regs_wr_ch
   import sm_regs_pkg::*;
#(
   parameter int unsigned C_DATA_WIDTH = 32,
   parameter int unsigned C_ADDR_WIDTH = 8,
   parameter int unsigned C_NUM_REGS   = 16,
   parameter logic [63:0] C_RO_MASK    = '0
)(
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [C_ADDR_WIDTH-1:0]   awaddr,
   input  logic                      awvalid,
   output logic                      awready,
   input  logic [C_DATA_WIDTH-1:0]   wdata,
   input  logic [C_DATA_WIDTH/8-1:0] wstrb,
   input  logic                      wvalid,
   output logic                      wready,
   output logic [1:0]                bresp,
   output logic                      bvalid,
   input  logic                      bready,
   output logic                      commit,
   output logic [IDX_W-1:0]          commit_idx,
   output logic [C_DATA_WIDTH-1:0]   commit_data,
   output logic [C_DATA_WIDTH/8-1:0] commit_strb
);

   wr_state_e                 state, state_nxt;
   logic                      rdy_en;
   logic                      aw_got, w_got;
   logic [C_ADDR_WIDTH-1:0]   aw_addr_q;
   logic [C_DATA_WIDTH-1:0]   w_data_q;
   logic [C_DATA_WIDTH/8-1:0] w_strb_q;
   logic                      aw_hs, w_hs, fire, legal;
   logic [C_ADDR_WIDTH-1:0]   addr_sel;
   int unsigned               idx;

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;

   // FSM state register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= W_IDLE;
      else          state <= state_nxt;
   end

   // Next state and channel handshake outputs; fire marks the completing handshake
   always_comb begin
      state_nxt = state;
      awready   = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;
      fire      = 1'b0;
      case (state)
         W_IDLE: begin
            awready = rdy_en && !aw_got;
            wready  = rdy_en && !w_got;
            fire    = (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready));
            if (fire) state_nxt = W_RESP;
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) state_nxt = W_IDLE;
         end
         default: state_nxt = W_IDLE;
      endcase
   end

   // Hold whichever of AW/W arrives first; record the response at commit
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rdy_en    <= 1'b0;
         aw_got    <= 1'b0;
         w_got     <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp     <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (fire) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            bresp  <= legal ? RESP_OKAY : RESP_SLVERR;
         end else begin
            if (aw_hs) begin
               aw_got    <= 1'b1;
               aw_addr_q <= awaddr;
            end
            if (w_hs) begin
               w_got    <= 1'b1;
               w_data_q <= wdata;
               w_strb_q <= wstrb;
            end
         end
      end
   end

   // Commit decode: latched value if already captured, else the live bus
   always_comb begin
      addr_sel    = aw_got ? aw_addr_q : awaddr;
      commit_data = w_got ? w_data_q : wdata;
      commit_strb = w_got ? w_strb_q : wstrb;
      idx         = addr_to_idx(32'(addr_sel), C_DATA_WIDTH);
      legal       = 1'b0;
      if (idx < C_NUM_REGS) legal = !mask_bit(C_RO_MASK, idx);
      commit      = fire && legal;
      commit_idx  = idx[IDX_W-1:0];
   end

endmodule

// File: rtl/sm_regs_bank.sv
// Parametrised AXI4-Lite register bank: RW control registers with byte
// strobes, RO status registers, SLVERR on illegal access, access pulses.
module sm_regs_bank
   import sm_regs_pkg::*;
#(
   parameter int unsigned C_DATA_WIDTH = 32,
   parameter int unsigned C_NUM_REGS   = 16,
   parameter int unsigned C_ADDR_WIDTH = 8,
   parameter logic [63:0] C_RO_MASK    = '0,
   parameter logic [C_NUM_REGS*C_DATA_WIDTH-1:0] C_RESET_VAL = '0
)(
   input  logic                               ACLK,
   input  logic                               ARESETN,
   input  logic [C_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
   input  logic [2:0]                         S_AXI_AWPROT,
   input  logic                               S_AXI_AWVALID,
   output logic                               S_AXI_AWREADY,
   input  logic [C_DATA_WIDTH-1:0]            S_AXI_WDATA,
   input  logic [C_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
   input  logic                               S_AXI_WVALID,
   output logic                               S_AXI_WREADY,
   output logic [1:0]                         S_AXI_BRESP,
   output logic                               S_AXI_BVALID,
   input  logic                               S_AXI_BREADY,
   input  logic [C_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
   input  logic [2:0]                         S_AXI_ARPROT,
   input  logic                               S_AXI_ARVALID,
   output logic                               S_AXI_ARREADY,
   output logic [C_DATA_WIDTH-1:0]            S_AXI_RDATA,
   output logic [1:0]                         S_AXI_RRESP,
   output logic                               S_AXI_RVALID,
   input  logic                               S_AXI_RREADY,
   output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] ctrl_o,
   input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] sts_i,
   output logic [C_NUM_REGS-1:0]              wr_pulse_o,
   output logic [C_NUM_REGS-1:0]              rd_pulse_o
);

   localparam int unsigned DW = C_DATA_WIDTH;
   localparam int unsigned NB = C_DATA_WIDTH / 8;

   logic [DW-1:0]         regs [C_NUM_REGS];
   logic                  commit;
   logic [IDX_W-1:0]      commit_idx;
   logic [DW-1:0]         commit_data;
   logic [NB-1:0]         commit_strb;
   logic [C_NUM_REGS-1:0] wr_hit, rd_hit;
   logic                  ar_en, ar_hs, rd_ok;
   logic [DW-1:0]         rd_word;
   int unsigned           ar_idx;
   logic                  unused_prot;

   assign unused_prot   = ^{S_AXI_AWPROT, S_AXI_ARPROT};
   assign S_AXI_ARREADY = ar_en && !S_AXI_RVALID;
   assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

   sm_regs_wr_ch #(
      .C_DATA_WIDTH (C_DATA_WIDTH),
      .C_ADDR_WIDTH (C_ADDR_WIDTH),
      .C_NUM_REGS   (C_NUM_REGS),
      .C_RO_MASK    (C_RO_MASK)
   ) u_wr_ch (
      .aclk        (ACLK),
      .aresetn     (ARESETN),
      .awaddr      (S_AXI_AWADDR),
      .awvalid     (S_AXI_AWVALID),
      .awready     (S_AXI_AWREADY),
      .wdata       (S_AXI_WDATA),
      .wstrb       (S_AXI_WSTRB),
      .wvalid      (S_AXI_WVALID),
      .wready      (S_AXI_WREADY),
      .bresp       (S_AXI_BRESP),
      .bvalid      (S_AXI_BVALID),
      .bready      (S_AXI_BREADY),
      .commit      (commit),
      .commit_idx  (commit_idx),
      .commit_data (commit_data),
      .commit_strb (commit_strb)
   );

   // Register array: reset image, then byte-strobed commits
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int unsigned i = 0; i < C_NUM_REGS; i++)
            regs[i] <= C_RESET_VAL[i*DW +: DW];
      end else if (commit) begin
         for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            if (commit_idx == IDX_W'(i)) begin
               for (int unsigned b = 0; b < NB; b++)
                  if (commit_strb[b]) regs[i][b*8 +: 8] <= commit_data[b*8 +: 8];
            end
         end
      end
   end

   // Read source select and per-register hit vectors for both channels
   always_comb begin
      ar_idx  = addr_to_idx(32'(S_AXI_ARADDR), DW);
      rd_word = '0;
      rd_ok   = 1'b0;
      rd_hit  = '0;
      wr_hit  = '0;
      for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
         if (ar_idx == i) begin
            rd_ok     = 1'b1;
            rd_hit[i] = 1'b1;
            rd_word   = mask_bit(C_RO_MASK, i) ? sts_i[i*DW +: DW] : regs[i];
         end
         wr_hit[i] = commit && (commit_idx == IDX_W'(i));
      end
   end

   // Read data channel; ARREADY is gated while RVALID is pending
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         ar_en        <= 1'b0;
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
         S_AXI_RRESP  <= '0;
      end else begin
         ar_en <= 1'b1;
         if (ar_hs) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_word;
            S_AXI_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
         end
      end
   end

   // One-cycle access pulses, aligned with BVALID/RVALID rising
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_pulse_o <= '0;
         rd_pulse_o <= '0;
      end else begin
         wr_pulse_o <= wr_hit;
         rd_pulse_o <= ar_hs ? rd_hit : '0;
      end
   end

   // Control outputs; read-only slices are driven to zero
   always_comb begin
      ctrl_o = '0;
      for (int unsigned i = 0; i < C_NUM_REGS; i++)
         if (!mask_bit(C_RO_MASK, i)) ctrl_o[i*DW +: DW] = regs[i];
   end

endmodule

// File: tb/tb_sm_regs_bank.sv
// Scoreboard bench for sm_regs_bank with register 2 configured read-only.
module tb_sm_regs_bank;
   import sm_regs_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned NR = 16;
   localparam int unsigned AW = 8;
   localparam int unsigned VW = NR * DW;
   localparam logic [63:0] RO = 64'h4;
   localparam logic [31:0] STS2 = 32'hCAFEF00D;

   logic           ACLK = 1'b0;
   logic           ARESETN = 1'b0;
   logic [AW-1:0]  S_AXI_AWADDR = '0;
   logic [2:0]     S_AXI_AWPROT = '0;
   logic           S_AXI_AWVALID = 1'b0;
   logic           S_AXI_AWREADY;
   logic [DW-1:0]  S_AXI_WDATA = '0;
   logic [3:0]     S_AXI_WSTRB = '0;
   logic           S_AXI_WVALID = 1'b0;
   logic           S_AXI_WREADY;
   logic [1:0]     S_AXI_BRESP;
   logic           S_AXI_BVALID;
   logic           S_AXI_BREADY = 1'b0;
   logic [AW-1:0]  S_AXI_ARADDR = '0;
   logic [2:0]     S_AXI_ARPROT = '0;
   logic           S_AXI_ARVALID = 1'b0;
   logic           S_AXI_ARREADY;
   logic [DW-1:0]  S_AXI_RDATA;
   logic [1:0]     S_AXI_RRESP;
   logic           S_AXI_RVALID;
   logic           S_AXI_RREADY = 1'b1;
   logic [VW-1:0]  ctrl_o;
   logic [VW-1:0]  sts_i = '0;
   logic [NR-1:0]  wr_pulse_o, rd_pulse_o;

   typedef struct {
      logic [1:0]    resp;
      logic [NR-1:0] pulse;
      logic [VW-1:0] ctrl;
   } wexp_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic [NR-1:0] pulse;
   } rexp_t;

   wexp_t         wq[$];
   rexp_t         rq[$];
   logic [31:0]   model [NR];
   int            n_checks = 0;
   int            n_pass = 0;
   logic          bvalid_prev = 1'b0;
   logic          rvalid_prev = 1'b0;

   always #5 ACLK = ~ACLK;

   sm_regs_bank #(
      .C_DATA_WIDTH (DW),
      .C_NUM_REGS   (NR),
      .C_ADDR_WIDTH (AW),
      .C_RO_MASK    (RO),
      .C_RESET_VAL  ('0)
   ) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .ctrl_o        (ctrl_o),
      .sts_i         (sts_i),
      .wr_pulse_o    (wr_pulse_o),
      .rd_pulse_o    (rd_pulse_o)
   );

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [VW-1:0] model_ctrl();
      logic [VW-1:0] v;
      v = '0;
      for (int i = 0; i < NR; i++)
         if (i != 2) v[i*DW +: DW] = model[i];
      return v;
   endfunction

   function automatic logic [NR-1:0] onehot(input int unsigned idx);
      logic [NR-1:0] p;
      p = '0;
      p[idx[3:0]] = 1'b1;
      return p;
   endfunction

   // Scoreboard: compare pulses/ctrl at response rise, pop on handshake
   always @(negedge ACLK) begin
      if (S_AXI_BVALID && !bvalid_prev) begin
         if (wq.size() == 0) check("wq_empty", 1, 0);
         else begin
            check("wr_pulse", wr_pulse_o, wq[0].pulse);
            check("ctrl_after_wr", ctrl_o, wq[0].ctrl);
         end
      end else begin
         check("wr_pulse_idle", wr_pulse_o, 0);
      end
      if (S_AXI_BVALID && S_AXI_BREADY && wq.size() > 0) begin
         check("bresp", S_AXI_BRESP, wq[0].resp);
         void'(wq.pop_front());
      end
      if (S_AXI_RVALID && !rvalid_prev) begin
         if (rq.size() == 0) check("rq_empty", 1, 0);
         else check("rd_pulse", rd_pulse_o, rq[0].pulse);
      end else begin
         check("rd_pulse_idle", rd_pulse_o, 0);
      end
      if (S_AXI_RVALID && S_AXI_RREADY && rq.size() > 0) begin
         check("rdata", S_AXI_RDATA, rq[0].data);
         check("rresp", S_AXI_RRESP, rq[0].resp);
         void'(rq.pop_front());
      end
      bvalid_prev <= S_AXI_BVALID;
      rvalid_prev <= S_AXI_RVALID;
   end

   // b_hold < 0 leaves the response pending on return
   task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input int b_hold);
      int unsigned idx;
      logic        legal, aw_done, w_done, aw_hs, w_hs, done;
      int          cnt;
      wexp_t       e;
      idx   = addr >> 2;
      legal = (idx < NR) && (idx != 2);
      if (legal)
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      e.resp  = legal ? RESP_OKAY : RESP_SLVERR;
      e.pulse = legal ? onehot(idx) : '0;
      e.ctrl  = model_ctrl();
      wq.push_back(e);
      S_AXI_AWADDR  = addr;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_WVALID  = 1'b1;
      S_AXI_AWVALID = (w_lead == 0);
      aw_done = 1'b0;
      w_done  = 1'b0;
      cnt     = 0;
      while (!(aw_done && w_done) && cnt < 20) begin
         @(negedge ACLK);
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         @(posedge ACLK); #1;
         if (aw_hs) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
         if (w_hs)  begin w_done = 1'b1;  S_AXI_WVALID = 1'b0; end
         cnt++;
         if (w_done && !aw_done && w_lead > 0) check("wready_after_w", S_AXI_WREADY, 0);
         if (!aw_done && !S_AXI_AWVALID && cnt >= w_lead) S_AXI_AWVALID = 1'b1;
      end
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      if (!(aw_done && w_done)) check("wr_hs_timeout", 0, 1);
      check("bvalid_next", S_AXI_BVALID, 1);
      for (int k = 0; k < b_hold; k++) begin
         @(negedge ACLK);
         check("bvalid_hold", S_AXI_BVALID, 1);
         check("awready_hold", S_AXI_AWREADY, 0);
         @(posedge ACLK); #1;
      end
      if (b_hold < 0) return;
      S_AXI_BREADY = 1'b1;
      done = 1'b0;
      cnt  = 0;
      while (!done && cnt < 20) begin
         @(negedge ACLK);
         done = S_AXI_BVALID;
         @(posedge ACLK); #1;
         cnt++;
      end
      S_AXI_BREADY = 1'b0;
      if (!done) check("b_timeout", 0, 1);
      check("awready_after_b", S_AXI_AWREADY, 1);
   endtask

   task automatic axi_read(input logic [AW-1:0] addr);
      int unsigned idx;
      logic        hs, done;
      int          cnt;
      rexp_t       e;
      idx = addr >> 2;
      if (idx < NR) begin
         e.data  = (idx == 2) ? STS2 : model[idx];
         e.resp  = RESP_OKAY;
         e.pulse = onehot(idx);
      end else begin
         e.data  = '0;
         e.resp  = RESP_SLVERR;
         e.pulse = '0;
      end
      rq.push_back(e);
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      done = 1'b0;
      cnt  = 0;
      while (!done && cnt < 20) begin
         @(negedge ACLK);
         hs = S_AXI_ARVALID && S_AXI_ARREADY;
         @(posedge ACLK); #1;
         if (hs) done = 1'b1;
         cnt++;
      end
      S_AXI_ARVALID = 1'b0;
      if (!done) check("ar_timeout", 0, 1);
      check("rvalid_next", S_AXI_RVALID, 1);
   endtask

   task automatic check_ready(input string tag, input logic exp);
      check({tag, "_awready"}, S_AXI_AWREADY, exp);
      check({tag, "_wready"},  S_AXI_WREADY,  exp);
      check({tag, "_arready"}, S_AXI_ARREADY, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < NR; i++) begin
         model[i] = '0;
         sts_i[i*DW +: DW] = $urandom;
      end
      sts_i[2*DW +: DW] = STS2;

      // reset behaviour
      repeat (3) @(negedge ACLK);
      check_ready("in_reset", 1'b0);
      check("rst_bvalid", S_AXI_BVALID, 0);
      check("rst_rvalid", S_AXI_RVALID, 0);
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      check_ready("pre_edge", 1'b0);
      @(posedge ACLK); #1;
      check_ready("post_rst", 1'b1);
      check("rst_ctrl", ctrl_o, 0);
      check("rst_bvalid_post", S_AXI_BVALID, 0);
      check("rst_rvalid_post", S_AXI_RVALID, 0);

      // write index value to every register, then read all back
      for (int i = 0; i < NR; i++) axi_write(AW'(i * 4), 32'(i), 4'hF, 0, 0);
      for (int i = 0; i < NR; i++) axi_read(AW'(i * 4));

      // byte strobes (register 3, since 2 is read-only here)
      axi_write(8'h0C, 32'h11223344, 4'hF, 0, 0);
      axi_write(8'h0C, 32'hAABBCCDD, 4'b0101, 0, 0);
      axi_read(8'h0C);
      check("strobe_model", 512'(model[3]), 512'(32'h11BB33DD));

      // read-only register
      axi_write(8'h08, 32'h12345678, 4'hF, 0, 0);
      axi_read(8'h08);
      check("ro_ctrl_zero", 512'(ctrl_o[2*DW +: DW]), 0);

      // out-of-range index and ignored low address bits
      axi_read(8'h40);
      axi_write(8'h40, 32'hDEADBEEF, 4'hF, 0, 0);
      axi_read(8'h0E);

      // W ahead of AW, then a held-off B response
      axi_write(8'h14, 32'h0BADF00D, 4'hF, 3, 0);
      axi_write(8'h18, 32'h5A5AA5A5, 4'hF, 0, 5);
      axi_read(8'h14);
      axi_read(8'h18);

      // random traffic including illegal addresses
      for (int i = 0; i < 12; i++)
         axi_write(AW'($urandom_range(0, 17) * 4), $urandom, 4'($urandom_range(0, 15)), 0,
                   int'($urandom_range(0, 2)));
      for (int i = 0; i < 18; i++) axi_read(AW'(i * 4));
      check("ctrl_final", ctrl_o, model_ctrl());

      // asynchronous reset while a write response is pending
      axi_write(8'h1C, 32'h55555555, 4'hF, 0, -1);
      #2;
      ARESETN = 1'b0;
      #1;
      check("mid_rst_bvalid", S_AXI_BVALID, 0);
      check("mid_rst_ctrl", ctrl_o, 0);
      check_ready("mid_rst", 1'b0);
      wq.delete();
      rq.delete();
      for (int i = 0; i < NR; i++) model[i] = '0;
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      @(posedge ACLK); #1;
      check_ready("after_mid_rst", 1'b1);
      axi_read(8'h1C);
      axi_read(8'h04);
      repeat (3) @(posedge ACLK);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
